// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and address-field constants for the cache refill engine
package cache_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int TAG_W           = 6;
  localparam int SET_W           = 6;
  localparam int WORD_W          = 3;
  localparam int SETS            = 64;
  localparam int WORDS_PER_BLOCK = 8;

  // Byte address layout: tag [15:10], set [9:4], word [3:1], byte [0]
  localparam int TAG_LSB  = 10;
  localparam int TAG_MSB  = 15;
  localparam int SET_LSB  = 4;
  localparam int SET_MSB  = 9;
  localparam int WORD_LSB = 1;
  localparam int WORD_MSB = 3;

  // Counters run 0..8; 8 means every word of the block has been handled
  localparam logic [3:0] CNT_FULL = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fill_state_e;

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - N-bit binary to 2^N one-hot decoder with enable
//   en     in   1       all outputs 0 when low
//   sel    in   N       index of the hot bit
//   onehot out  2^N     decoded one-hot vector
module onehot_dec #(
  parameter int N = 3
) (
  input  logic                en,
  input  logic [N-1:0]        sel,
  output logic [(1<<N)-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - miss-refill engine for the 2-way set-associative data cache
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   miss_req/addr/way    fill request from the cache FSM, sampled in IDLE only
//   busy, fill_done      fill in progress / one-cycle completion pulse
//   mem_rd_en, mem_addr  registered word read requests to main memory
//   mem_data_valid/data  in-order returned words
//   da_data_in/write     data array write data and one-hot per-way strobe
//   da_block_en/word_en  one-hot set and word selects, hot only on write cycles
//   ta_write, ta_tag     tag array write strobe and tag, on the last word
// Build option: FILL_CRIT_WORD_FIRST_EN starts the fill at the missed word.
module cache_fill_ctrl
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 miss_req,
  input  logic [ADDR_W-1:0]    miss_addr,
  input  logic                 miss_way,
  output logic                 busy,
  output logic                 fill_done,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_data_valid,
  input  logic [DATA_W-1:0]    mem_data,
  output logic [DATA_W-1:0]    da_data_in,
  output logic [1:0]           da_write,
  output logic [SETS-1:0]      da_block_en,
  output logic [WORDS_PER_BLOCK-1:0] da_word_en,
  output logic [1:0]           ta_write,
  output logic [TAG_W-1:0]     ta_tag
);

  fill_state_e        state_q, state_d;
  logic [3:0]         issue_cnt_q, issue_cnt_d;
  logic [3:0]         ret_cnt_q, ret_cnt_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic               way_q, way_d;
  logic [WORD_W-1:0]  start_q, start_d;
  logic               rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               done_q, done_d;

  logic [WORD_W-1:0]  miss_start;
  logic [WORD_W-1:0]  issue_word;
  logic [WORD_W-1:0]  ret_word;
  logic               wr_hit;
  logic               last_ret;
  logic               addr_unused;

`ifdef FILL_CRIT_WORD_FIRST_EN
  assign miss_start = miss_addr[WORD_MSB:WORD_LSB];
`else
  assign miss_start = '0;
`endif

  // Byte offset never reaches memory; word offset is unused without the option
  assign addr_unused = ^miss_addr[WORD_MSB:0];

  // Word arithmetic is 3 bits wide so the order wraps 7 -> 0
  assign issue_word = start_q + issue_cnt_q[WORD_W-1:0];
  assign ret_word   = start_q + ret_cnt_q[WORD_W-1:0];

  // A return counts only while a fill is open and the block is not yet complete
  assign wr_hit   = (state_q != ST_IDLE) && mem_data_valid && (ret_cnt_q < CNT_FULL);
  assign last_ret = wr_hit && (ret_cnt_q == CNT_FULL - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      tag_q       <= '0;
      set_q       <= '0;
      way_q       <= 1'b0;
      start_q     <= '0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      tag_q       <= tag_d;
      set_q       <= set_d;
      way_q       <= way_d;
      start_q     <= start_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
    end
  end

  // issue_cnt holds the number of reads already presented on mem_rd_en
  // (including the one visible this cycle), so the request for the next
  // cycle is prepared one edge ahead and leaves on a registered output.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    tag_d       = tag_q;
    set_d       = set_q;
    way_d       = way_q;
    start_d     = start_q;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    done_d      = 1'b0;

    if (wr_hit) ret_cnt_d = ret_cnt_q + 4'd1;

    case (state_q)
      ST_IDLE: begin
        if (miss_req) begin
          state_d     = ST_ISSUE;
          tag_d       = miss_addr[TAG_MSB:TAG_LSB];
          set_d       = miss_addr[SET_MSB:SET_LSB];
          way_d       = miss_way;
          start_d     = miss_start;
          issue_cnt_d = 4'd1;
          ret_cnt_d   = '0;
          rd_en_d     = 1'b1;
          addr_d      = {miss_addr[TAG_MSB:SET_LSB], miss_start, 1'b0};
        end
      end
      ST_ISSUE: begin
        if (last_ret) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (issue_cnt_q < CNT_FULL) begin
          rd_en_d     = 1'b1;
          addr_d      = {tag_q, set_q, issue_word, 1'b0};
          issue_cnt_d = issue_cnt_q + 4'd1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_ret) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign fill_done  = done_q;
  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;

  assign da_data_in = wr_hit ? mem_data : '0;
  assign da_write   = wr_hit ? (way_q ? 2'b10 : 2'b01) : 2'b00;
  assign ta_write   = last_ret ? (way_q ? 2'b10 : 2'b01) : 2'b00;
  assign ta_tag     = last_ret ? tag_q : '0;

  onehot_dec #(.N(SET_W)) u_block_dec (
    .en     (wr_hit),
    .sel    (set_q),
    .onehot (da_block_en)
  );

  onehot_dec #(.N(WORD_W)) u_word_dec (
    .en     (wr_hit),
    .sel    (ret_word),
    .onehot (da_word_en)
  );

endmodule
